// File: rtl/rv32_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store.
// Data has priority; a starvation counter bounds fetch wait. Optional ack timeout: RV32_ARB_TIMEOUT_EN.
module rv32_mem_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        if_stall,
  output logic        d_stall,
  output logic        bus_err
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    GNT_IF,
    GNT_D
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  logic             mem_req_nxt, mem_we_nxt;
  logic [31:0]      mem_addr_nxt, mem_wdata_nxt;
  logic [31:0]      if_rdata_nxt, d_rdata_nxt;
  logic             if_valid_nxt, d_valid_nxt;
  logic             if_cand, d_cand, fetch_wins;

`ifdef RV32_ARB_TIMEOUT_EN
  localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      NOP_INSN = 32'h0000_0013;

  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic             tmo_expired;
  logic             bus_err_nxt;

  assign tmo_expired = (tmo_cnt == TMO_LAST);
`endif

  // A requester whose valid is high this cycle is holding req for a new transaction; skip it once.
  assign if_cand    = if_req & ~if_valid;
  assign d_cand     = d_req & ~d_valid;
  assign fetch_wins = if_cand & (~d_cand | (starve_cnt == CNT_MAX));

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    mem_req_nxt    = mem_req;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    if_rdata_nxt   = if_rdata;
    d_rdata_nxt    = d_rdata;
    if_valid_nxt   = 1'b0;
    d_valid_nxt    = 1'b0;
`ifdef RV32_ARB_TIMEOUT_EN
    tmo_cnt_nxt    = '0;
    bus_err_nxt    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (fetch_wins) begin
          state_nxt      = GNT_IF;
          mem_req_nxt    = 1'b1;
          mem_we_nxt     = 1'b0;
          mem_addr_nxt   = if_addr;
          starve_cnt_nxt = '0;
        end else if (d_cand) begin
          state_nxt     = GNT_D;
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = d_we;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
          if (if_req && (starve_cnt != CNT_MAX)) begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
          end
        end
      end
      GNT_IF, GNT_D: begin
        if (mem_ack) begin
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          if (state == GNT_IF) begin
            if_rdata_nxt = mem_rdata;
            if_valid_nxt = 1'b1;
          end else begin
            if (!mem_we) begin
              d_rdata_nxt = mem_rdata;
            end
            d_valid_nxt = 1'b1;
          end
`ifdef RV32_ARB_TIMEOUT_EN
        end else if (tmo_expired) begin
          // Abort: the requester still gets its valid so the pipeline can move on.
          state_nxt   = IDLE;
          mem_req_nxt = 1'b0;
          mem_we_nxt  = 1'b0;
          bus_err_nxt = 1'b1;
          if (state == GNT_IF) begin
            if_rdata_nxt = NOP_INSN;
            if_valid_nxt = 1'b1;
          end else begin
            d_rdata_nxt = 32'h0;
            d_valid_nxt = 1'b1;
          end
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
`endif
        end
      end
      default: begin
        state_nxt   = IDLE;
        mem_req_nxt = 1'b0;
        mem_we_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      if_rdata   <= 32'h0;
      d_rdata    <= 32'h0;
      if_valid   <= 1'b0;
      d_valid    <= 1'b0;
`ifdef RV32_ARB_TIMEOUT_EN
      tmo_cnt    <= '0;
      bus_err    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      if_valid   <= if_valid_nxt;
      d_valid    <= d_valid_nxt;
`ifdef RV32_ARB_TIMEOUT_EN
      tmo_cnt    <= tmo_cnt_nxt;
      bus_err    <= bus_err_nxt;
`endif
    end
  end

`ifndef RV32_ARB_TIMEOUT_EN
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Randomized bench for rv32_mem_arbiter: a transaction-level arbitration model predicts every
// output each cycle; a small memory responder acks after a random delay and injects stray acks.
module tb_rv32_mem_arbiter;
  localparam int STARVE_LIMIT = 4;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b1;
  logic        if_req    = 1'b0;
  logic [31:0] if_addr   = 32'h0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req     = 1'b0;
  logic        d_we      = 1'b0;
  logic [31:0] d_addr    = 32'h0;
  logic [31:0] d_wdata   = 32'h0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack   = 1'b0;
  logic        if_stall;
  logic        d_stall;
  logic        bus_err;

  always #5 clk = ~clk;

  rv32_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .if_stall(if_stall), .d_stall(d_stall), .bus_err(bus_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents: a few fixed words, everything else a hash of the address.
  logic [31:0] preload [logic [31:0]];
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (preload.exists(a)) return preload[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  // Reference model state: one transaction in flight at a time.
  logic        m_busy, m_is_data, m_we;
  int          m_starve;
  logic        e_mem_req, e_mem_we, e_if_valid, e_d_valid;
  logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;

  task automatic model_reset();
    m_busy = 0; m_is_data = 0; m_we = 0; m_starve = 0;
    e_mem_req = 0; e_mem_we = 0; e_if_valid = 0; e_d_valid = 0;
    e_mem_addr = 0; e_mem_wdata = 0; e_if_rdata = 0; e_d_rdata = 0;
  endtask

  task automatic model_edge();
    logic want_if, want_d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    want_if = if_req && !e_if_valid;
    want_d  = d_req && !e_d_valid;
    e_if_valid = 0;
    e_d_valid  = 0;
    if (!m_busy) begin
      if (want_if && (!want_d || m_starve == STARVE_LIMIT)) begin
        m_busy = 1; m_is_data = 0; m_we = 0; m_starve = 0;
        e_mem_req = 1; e_mem_we = 0; e_mem_addr = if_addr;
      end else if (want_d) begin
        m_busy = 1; m_is_data = 1; m_we = d_we;
        e_mem_req = 1; e_mem_we = d_we; e_mem_addr = d_addr; e_mem_wdata = d_wdata;
        if (if_req && m_starve < STARVE_LIMIT) m_starve++;
      end
    end else if (mem_ack) begin
      m_busy = 0;
      e_mem_req = 0;
      e_mem_we = 0;
      if (!m_is_data) begin
        e_if_rdata = mem_val(e_mem_addr);
        e_if_valid = 1;
      end else begin
        if (!m_we) e_d_rdata = mem_val(e_mem_addr);
        e_d_valid = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("mem_req",   32'(mem_req),  32'(e_mem_req));
    chk("mem_we",    32'(mem_we),   32'(e_mem_we));
    chk("mem_addr",  mem_addr,      e_mem_addr);
    chk("mem_wdata", mem_wdata,     e_mem_wdata);
    chk("if_rdata",  if_rdata,      e_if_rdata);
    chk("d_rdata",   d_rdata,       e_d_rdata);
    chk("if_valid",  32'(if_valid), 32'(e_if_valid));
    chk("d_valid",   32'(d_valid),  32'(e_d_valid));
    chk("bus_err",   32'(bus_err),  32'h0);
    chk("if_stall",  32'(if_stall), 32'(if_req & ~e_if_valid));
    chk("d_stall",   32'(d_stall),  32'(d_req & ~e_d_valid));
  endtask

  // Memory responder: ack a held mem_req after fixed_delay (or random 1..4) cycles.
  logic ack_armed   = 1'b0;
  int   ack_wait    = 0;
  int   fixed_delay = 1;
  logic noise_en    = 1'b0;

  task automatic mem_drive();
    if (!rst_n) begin
      mem_ack = 0;
      ack_armed = 0;
      return;
    end
    if (mem_ack) begin
      mem_ack = 0;
      mem_rdata = $urandom;
    end else if (ack_armed) begin
      ack_wait--;
      if (ack_wait <= 0) begin
        mem_ack = 1;
        mem_rdata = mem_val(mem_addr);
        ack_armed = 0;
      end
    end else if (mem_req) begin
      ack_armed = 1;
      ack_wait = (fixed_delay > 0) ? fixed_delay : int'($urandom_range(1, 4));
    end else if (noise_en && $urandom_range(0, 15) == 0) begin
      mem_ack = 1;
      mem_rdata = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
    mem_drive();
  endtask

  int f_gap = 0;
  int d_gap = 0;

  task automatic drive_random();
    if (if_req) begin
      if (if_valid && $urandom_range(0, 1) == 0) begin
        if_req = 0;
        f_gap = $urandom_range(0, 3);
      end
    end else if (f_gap > 0) f_gap--;
    else if ($urandom_range(0, 2) == 0) begin
      if_req = 1;
      if_addr = $urandom;
    end
    if (d_req) begin
      if (d_valid && $urandom_range(0, 1) == 0) begin
        d_req = 0;
        d_gap = $urandom_range(0, 3);
      end
    end else if (d_gap > 0) d_gap--;
    else if ($urandom_range(0, 1) == 0) begin
      d_req = 1;
      d_we = $urandom_range(0, 1);
      d_addr = $urandom;
      d_wdata = $urandom;
    end
  endtask

  initial begin
    int cyc;
    int nd;
    int nf;
    int n_if;
    int n_d;
    logic [31:0] keep;

    preload[32'h0000_0100] = 32'h00A0_0093;
    preload[32'h0000_2000] = 32'hDEAD_BEEF;
    model_reset();

    // Reset state: outputs must clear before any clock edge.
    #2 rst_n = 0;
    #1 compare_all();
    repeat (2) step();
    rst_n = 1;
    step();

    // Fetch only, memory acks one cycle after mem_req rises.
    if_req = 1; if_addr = 32'h100;
    step();
    chk("t1_mem_addr", mem_addr, 32'h100);
    chk("t1_mem_we", 32'(mem_we), 32'h0);
    cyc = 1;
    while (!if_valid && cyc < 20) begin step(); cyc++; end
    chk("t1_latency", 32'(cyc), 32'd3);
    chk("t1_rdata", if_rdata, 32'h00A0_0093);
    if_req = 0;
    step();
    chk("t1_single_pulse", 32'(if_valid), 32'h0);

    // Simultaneous requests: data first, fetch right after d_valid.
    if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h2000;
    step();
    chk("t2_data_first", mem_addr, 32'h2000);
    cyc = 0;
    while (!d_valid && cyc < 20) begin step(); cyc++; end
    chk("t2_d_valid", 32'(d_valid), 32'h1);
    chk("t2_d_rdata", d_rdata, 32'hDEAD_BEEF);
    d_req = 0;
    step();
    chk("t2_fetch_req", 32'(mem_req), 32'h1);
    chk("t2_fetch_addr", mem_addr, 32'h104);
    cyc = 0;
    while (!if_valid && cyc < 20) begin step(); cyc++; end
    chk("t2_if_valid", 32'(if_valid), 32'h1);
    if_req = 0;
    step();

    // Six back-to-back loads with a fetch held pending the whole time.
    fixed_delay = 2;
    d_req = 1; d_we = 0; d_addr = 32'h5000; if_req = 1; if_addr = 32'h200;
    nd = 0; nf = 0; cyc = 0;
    while (nd < 6 && cyc < 200) begin
      step(); cyc++;
      if (d_valid) begin nd++; if (nd == 6) d_req = 0; end
      if (if_valid) nf++;
    end
    chk("t3_loads_done", 32'(nd), 32'd6);
    chk("t3_fetch_served", 32'(nf >= 1), 32'h1);
    cyc = 0;
    while (cyc < 20) begin
      step(); cyc++;
      if (if_valid) begin if_req = 0; break; end
    end
    chk("t3_drain", 32'(if_req), 32'h0);
    repeat (2) step();

    // Store: write enable and data held until ack, d_rdata untouched.
    fixed_delay = 3;
    keep = e_d_rdata;
    d_req = 1; d_we = 1; d_addr = 32'h3000; d_wdata = 32'h1234_5678;
    step();
    chk("t4_mem_we", 32'(mem_we), 32'h1);
    chk("t4_mem_wdata", mem_wdata, 32'h1234_5678);
    chk("t4_mem_addr", mem_addr, 32'h3000);
    cyc = 0;
    while (!d_valid && cyc < 20) begin
      chk("t4_we_held", 32'(mem_we), 32'h1);
      step(); cyc++;
    end
    chk("t4_d_valid", 32'(d_valid), 32'h1);
    chk("t4_rdata_kept", d_rdata, keep);
    d_req = 0;
    nd = 0;
    repeat (4) begin step(); if (d_valid) nd++; end
    chk("t4_one_pulse", 32'(nd), 32'h0);

    // Reset while a load is outstanding, then a stray late ack.
    fixed_delay = 4;
    d_req = 1; d_we = 0; d_addr = 32'h4000;
    step();
    chk("t5_req_before", 32'(mem_req), 32'h1);
    rst_n = 0;
    #1;
    chk("t5_req_async", 32'(mem_req), 32'h0);
    chk("t5_addr_async", mem_addr, 32'h0);
    chk("t5_we_async", 32'(mem_we), 32'h0);
    d_req = 0;
    ack_armed = 0;
    step();
    rst_n = 1;
    mem_ack = 1;
    mem_rdata = 32'hBAD0_BAD0;
    nd = 0;
    repeat (4) begin step(); if (d_valid) nd++; end
    chk("t5_no_valid", 32'(nd), 32'h0);
    chk("t5_d_rdata", d_rdata, 32'h0);

    // Randomized traffic with random ack delays and stray acks.
    fixed_delay = 0;
    noise_en = 1;
    n_if = 0; n_d = 0;
    repeat (3000) begin
      step();
      if (if_valid) n_if++;
      if (d_valid) n_d++;
      drive_random();
    end
    chk("rand_fetch_progress", 32'(n_if >= 50), 32'h1);
    chk("rand_data_progress", 32'(n_d >= 50), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32_mem_arbiter.md
Name: rv32_mem_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch requester and the data load/store requester.
- Sits between the pipeline's fetch/data ports and the external memory.
- Arbitrates between the two requesters, sequences one memory transaction at a time with a req/ack handshake, and returns read data.
- Drives stall flags back to the pipeline.
- Data has priority; a starvation counter bounds how long fetch can wait.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while a fetch is pending before fetch is forced to win.
- TIMEOUT_CYCLES, 64: cycles to wait for mem_ack before aborting. Used only with RV32_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch request; level, held until if_valid.
- if_addr  in  32  fetch address; stable while if_req is high.
- if_rdata  out  32  fetched word.
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- d_req  in  1  data request; level, held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data.
- d_valid  out  1  one-cycle pulse: data transaction complete.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data; valid while mem_ack is high.
- mem_ack  in  1  one-cycle completion from memory.
- if_stall  out  1  combinational: if_req & ~if_valid.
- d_stall  out  1  combinational: d_req & ~d_valid.
- bus_err  out  1  one-cycle pulse: transaction aborted by timeout.

Behaviour:
- Reset: all registered outputs go to 0 immediately and asynchronously. This includes mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_valid, d_valid and bus_err. The FSM returns to IDLE and the starvation count is cleared.
- An in-flight transaction is abandoned on reset. A late mem_ack arriving after reset is ignored.
- FSM states: IDLE, GNT_IF, GNT_D. All memory-side outputs are registered.
- IDLE:
  - Each requester is masked in any cycle where its own valid is high, so a held req is not re-granted in the same cycle.
  - Only d_req: go to GNT_D and load mem_addr/mem_we/mem_wdata from the d_* inputs.
  - Only if_req: go to GNT_IF, with mem_addr = if_addr and mem_we = 0.
  - Both requesting: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - In every case where a grant is issued, mem_req is set to 1 at the same edge.
- starve_cnt:
  - Increments on each data grant made while if_req is pending, saturating at STARVE_LIMIT.
  - Clears on every fetch grant.
- GNT_x: hold all memory outputs until mem_ack is high. On that edge:
  - mem_req and mem_we go to 0.
  - GNT_IF: if_rdata is loaded from mem_rdata.
  - GNT_D: d_rdata is loaded from mem_rdata on a load; on a store it keeps its value.
  - The matching valid goes to 1 for exactly one cycle.
  - The FSM returns to IDLE.
- Latency:
  - Minimum is 3 cycles from req high to valid high, when mem_ack arrives in the first cycle after mem_req rises.
  - A requester that holds req after its valid pulse gets its next grant no earlier than the cycle after valid.
- mem_ack seen in IDLE is ignored.
- A requester dropping req mid-transaction is illegal. The transaction still completes and valid still pulses.
- Address/width: all 32-bit values pass through unmodified; no alignment checking.

Optional Feature:
- Macro: RV32_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in GNT_x and clears on entry to GNT_x.
  - If TIMEOUT_CYCLES cycles pass without mem_ack: mem_req goes to 0, the FSM returns to IDLE, and the matching valid pulses.
  - On a fetch timeout, if_rdata is forced to 32'h0000_0013 (NOP). On a data timeout, d_rdata is forced to 0.
  - bus_err pulses for one cycle alongside valid.
  - mem_ack arriving in the same cycle the count expires wins: the transaction completes normally with no error.
- Undefined: the arbiter waits indefinitely for mem_ack; bus_err is tied to 0.

Test Plan:
- Fetch only: if_addr = 0x100, memory acks 1 cycle after mem_req with 0x00A00093 -> mem_addr = 0x100, mem_we = 0; if_valid pulses 3 cycles after if_req with if_rdata = 0x00A00093.
- Simultaneous if_req and d_req (load, 0x2000, ack data 0xDEADBEEF) -> data granted first; d_rdata = 0xDEADBEEF; fetch granted in the cycle after d_valid.
- d_req held for 6 back-to-back loads while if_req is pending, STARVE_LIMIT = 4 -> 4 data grants, then 1 fetch grant, then data resumes.
- Store: d_we = 1, d_addr = 0x3000, d_wdata = 0x12345678 -> mem_we = 1 and mem_wdata = 0x12345678 until ack; d_rdata unchanged; d_valid pulses once.
- rst_n low while in GNT_D with mem_req high -> mem_req = 0 immediately; a late mem_ack is ignored; no valid pulse.
- With RV32_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, fetch with no ack -> mem_req drops after 8 cycles; if_valid and bus_err pulse together; if_rdata = 0x00000013.
